// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DATA_W     = 8;
    localparam int OVERSAMPLE = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_CAPTURE = 2'd2
    } rx_state_t;

endpackage

// File: rtl/rx_fifo.sv
// Small first-word-fall-through byte FIFO.
// Holds storage, pointers and occupancy only; no error flags.
module rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DATA_W-1:0]      din,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the slot, so a full FIFO still accepts a push alongside it.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side controller: frames -> FIFO -> valid/ready consumer,
// with overrun, stuck-frame and idle-with-data reporting.
import uart_pkg::*;

module uart_rx_ctrl #(
    parameter int DEPTH        = 4,
    parameter int IDLE_TIMEOUT = 96,
    parameter int MAX_FRAME    = 80
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_status,
    input  logic [DATA_W-1:0]      rx_byte,
    input  logic                   rd_ready,
    input  logic                   clr_err,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   rx_busy,
    output logic                   overrun,
    output logic                   frame_err,
    output logic                   idle_irq
);

    localparam int FW = $clog2(MAX_FRAME + 1);
    localparam int TW = $clog2(IDLE_TIMEOUT + 1);

    rx_state_t     state;
    rx_state_t     state_n;
    logic [FW-1:0] frame_cnt;
    logic [FW-1:0] frame_cnt_n;
    logic [TW-1:0] idle_tmr;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          frame_set;
    logic          ovr_set;

    rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_byte),
        .dout  (rd_data),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    assign rd_valid = ~empty;
    assign pop      = rd_valid & rd_ready;
    assign ovr_set  = push & full & ~pop;
    assign rx_busy  = (state == ST_RECV);
    assign idle_irq = (idle_tmr == TW'(IDLE_TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    // A saturated frame counter marks an aborted frame: it is not captured.
    always_comb begin
        state_n     = state;
        frame_cnt_n = frame_cnt;
        push        = 1'b0;
        frame_set   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_status) begin
                    state_n     = ST_RECV;
                    frame_cnt_n = '0;
                end
            end
            ST_RECV: begin
                if (!rx_status) begin
                    state_n = (frame_cnt == FW'(MAX_FRAME)) ? ST_IDLE
                                                            : ST_CAPTURE;
                end else if (frame_cnt != FW'(MAX_FRAME)) begin
                    frame_cnt_n = frame_cnt + 1'b1;
                    frame_set   = (frame_cnt == FW'(MAX_FRAME - 1));
                end
            end
            ST_CAPTURE: begin
                push        = 1'b1;
                frame_cnt_n = '0;
                state_n     = rx_status ? ST_RECV : ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_err) overrun <= 1'b0;
            if (frame_set)    frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_tmr <= '0;
        end else if (push || pop || state != ST_IDLE) begin
            idle_tmr <= '0;
        end else if (fifo_count != '0 && !idle_irq) begin
            idle_tmr <= idle_tmr + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl.
// Expected values are hand-derived from the cycle timing of the FSM.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_status;
    logic [7:0] rx_byte;
    logic       rd_ready;
    logic       clr_err;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [2:0] fifo_count;
    logic       rx_busy;
    logic       overrun;
    logic       frame_err;
    logic       idle_irq;

    int n_total = 0;
    int n_pass  = 0;

    uart_rx_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rx_status  (rx_status),
        .rx_byte    (rx_byte),
        .rd_ready   (rd_ready),
        .clr_err    (clr_err),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_count (fifo_count),
        .rx_busy    (rx_busy),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .idle_irq   (idle_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame of len busy cycles; rd_ready optionally high in the capture cycle.
    task automatic send(input logic [7:0] b, input int len, input logic pop);
        rx_status = 1'b1;
        rx_byte   = 8'hFF;
        repeat (len) tick();
        rx_status = 1'b0;
        rx_byte   = b;
        tick();
        rd_ready  = pop;
        tick();
        rd_ready  = 1'b0;
        rx_byte   = 8'h00;
    endtask

    task automatic drain(input string tag, input logic [7:0] b);
        check({tag, "_valid"}, rd_valid, 1'b1);
        check({tag, "_data"}, rd_data, b);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        rx_status = 1'b0;
        rx_byte   = 8'h00;
        rd_ready  = 1'b0;
        clr_err   = 1'b0;
        repeat (3) tick();
        check("rst_valid", rd_valid, 1'b0);
        check("rst_data", rd_data, 8'h00);
        check("rst_count", fifo_count, 3'd0);
        check("rst_busy", rx_busy, 1'b0);
        check("rst_flags", {overrun, frame_err, idle_irq}, 3'b000);
        rst = 1'b0;
        tick();

        // Single byte, capture latency, then idle timeout
        rx_status = 1'b1;
        rx_byte   = 8'hFF;
        repeat (72) tick();
        check("one_busy", rx_busy, 1'b1);
        rx_status = 1'b0;
        rx_byte   = 8'hA5;
        tick();
        check("one_capture_valid", rd_valid, 1'b0);
        tick();
        rx_byte = 8'h00;
        check("one_valid", rd_valid, 1'b1);
        check("one_data", rd_data, 8'hA5);
        check("one_count", fifo_count, 3'd1);
        check("one_busy_off", rx_busy, 1'b0);
        repeat (95) tick();
        check("idle_95", idle_irq, 1'b0);
        tick();
        check("idle_96", idle_irq, 1'b1);
        repeat (5) tick();
        check("idle_hold", idle_irq, 1'b1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("idle_pop", idle_irq, 1'b0);
        check("idle_pop_count", fifo_count, 3'd0);

        // Fill to full, then overrun
        for (int i = 1; i <= 4; i++) send(8'(i), 72, 1'b0);
        check("fill_count4", fifo_count, 3'd4);
        check("fill_no_ovr", overrun, 1'b0);
        send(8'h05, 72, 1'b0);
        check("ovr_count", fifo_count, 3'd4);
        check("ovr_flag", overrun, 1'b1);
        drain("pop1", 8'h01);
        drain("pop2", 8'h02);
        drain("pop3", 8'h03);
        drain("pop4", 8'h04);
        check("drained", {rd_valid, fifo_count}, 4'h0);
        check("ovr_sticky", overrun, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("ovr_clr", overrun, 1'b0);

        // Full with simultaneous pop on the capture edge
        for (int i = 1; i <= 4; i++) send(8'h10 + 8'(i), 72, 1'b0);
        send(8'h55, 72, 1'b1);
        check("sim_count", fifo_count, 3'd4);
        check("sim_ovr", overrun, 1'b0);
        drain("sim1", 8'h12);
        drain("sim2", 8'h13);
        drain("sim3", 8'h14);
        drain("sim4", 8'h55);
        check("sim_empty", fifo_count, 3'd0);

        // Stuck line
        rx_status = 1'b1;
        rx_byte   = 8'hEE;
        repeat (80) tick();
        check("stuck_80", frame_err, 1'b0);
        tick();
        check("stuck_81", frame_err, 1'b1);
        repeat (19) tick();
        check("stuck_busy", rx_busy, 1'b1);
        rx_status = 1'b0;
        repeat (2) tick();
        check("stuck_nopush", fifo_count, 3'd0);
        check("stuck_idle", rx_busy, 1'b0);
        check("stuck_sticky", frame_err, 1'b1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("stuck_clr", frame_err, 1'b0);

        // Reset mid-frame
        send(8'h77, 72, 1'b0);
        check("mid_pre", fifo_count, 3'd1);
        rx_status = 1'b1;
        rx_byte   = 8'hFF;
        repeat (30) tick();
        #2 rst = 1'b1;
        #1;
        check("mid_rst_count", fifo_count, 3'd0);
        check("mid_rst_out", {rd_valid, rd_data, rx_busy}, 10'h0);
        tick();
        rst = 1'b0;
        repeat (42) tick();
        check("mid_busy", rx_busy, 1'b1);
        rx_status = 1'b0;
        rx_byte   = 8'h3C;
        repeat (2) tick();
        check("mid_count", fifo_count, 3'd1);
        check("mid_data", rd_data, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
